shark_mover: RTL and testbench

//  Generates the sharkX/sharkY position and active flag consumed by the shark

---
 rtl/shark_pkg.sv | 34 +++
 rtl/shark_mover_lfsr10.sv | 29 ++
 rtl/shark_mover.sv | 199 +++++++++++++++++++
 tb/tb_shark_mover.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shark_pkg.sv
// shark_pkg: types and constants shared by the shark mover and the shark drawing logic.
// Ports: none (package). Provides the movement state enum, the coordinate type,
//        the sprite extents around the reference point and a coordinate clamp helper.

package shark_pkg;

  localparam int COORD_W = 12;

  // Sprite extents relative to (sharkX, sharkY): body spans X-LEFT..X+RIGHT, Y-TOP..Y+BOT.
  localparam int SHARK_LEFT  = 55;
  localparam int SHARK_RIGHT = 2;
  localparam int SHARK_TOP   = 15;
  localparam int SHARK_BOT   = 10;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE,
    SPAWN,
    SWIM,
    WAIT
  } shark_state_e;

  function automatic coord_t clamp_coord(input coord_t v, input coord_t lo, input coord_t hi);
    if (v < lo) begin
      return lo;
    end
    if (v > hi) begin
      return hi;
    end
    return v;
  endfunction

endpackage

// File: rtl/shark_mover_lfsr10.sv
// lfsr10: free-running 10-bit Fibonacci LFSR, polynomial x^10 + x^7 + 1.
// Ports: clk, rst (async, active-high, loads SEED), lfsr_o = current register state.
// Advances on every clock edge; SEED must be non-zero or the register locks at zero.

module lfsr10 #(
  parameter logic [9:0] SEED = 10'h2A5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] lfsr_o
);

  logic [9:0] lfsr_q;
  logic [9:0] lfsr_d;

  // Taps 10 and 7 (1-based) feed back into bit 0 as the register shifts up.
  assign lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/shark_mover.sv
// shark_mover: per-frame shark position/active generator; swims right-to-left with a
// vertical bob, respawns at a pseudo-random depth after escaping or being hit.
// Ports: clk, rst (async active-high), frame_tick, enable, hit in; sharkX, sharkY (signed),
//        active, escaped (one-cycle pulse) out. All outputs are registered.

module shark_mover
  import shark_pkg::*;
#(
  parameter int         H_ACTIVE       = 640,
  parameter int         V_TOP          = 40,
  parameter int         V_BOT          = 440,
  parameter int         SPEED          = 2,
  parameter int         STEP_DIV       = 1,
  parameter int         BOB_AMP        = 8,
  parameter int         RESPAWN_FRAMES = 30,
  parameter logic [9:0] LFSR_SEED      = 10'h2A5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               enable,
  input  logic               hit,
  output logic signed [11:0] sharkX,
  output logic signed [11:0] sharkY,
  output logic               active,
  output logic               escaped
);

  localparam coord_t SPAWN_X  = coord_t'(H_ACTIVE + 56);
  localparam coord_t CENTER_Y = coord_t'((V_TOP + V_BOT) / 2);
  localparam coord_t V_TOP_C  = coord_t'(V_TOP);
  localparam coord_t V_BOT_C  = coord_t'(V_BOT);
  localparam coord_t BAND_LO  = coord_t'(V_TOP + BOB_AMP);
  localparam coord_t BAND_HI  = coord_t'(V_BOT - BOB_AMP);
  localparam coord_t WRAP     = coord_t'(256);
  localparam coord_t SPEED_C  = coord_t'(SPEED);
  localparam coord_t AMP_P    = coord_t'(BOB_AMP);
  localparam coord_t AMP_N    = coord_t'(-BOB_AMP);
  localparam coord_t ONE      = coord_t'(1);
  // The body's right edge is X+SHARK_RIGHT; once that is left of column 0 the shark is gone.
  localparam coord_t ESC_X    = coord_t'(-(SHARK_RIGHT + 1));

  localparam logic [3:0] STEP_DIV_C = 4'(STEP_DIV);
  localparam logic [3:0] STEP_ONE   = 4'd1;

  localparam int                WAIT_W   = $clog2(RESPAWN_FRAMES + 1);
  localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(RESPAWN_FRAMES);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  shark_state_e      state_q, state_d;
  coord_t            x_q, x_d;
  coord_t            y_q, y_d;
  coord_t            base_q, base_d;
  coord_t            bob_q, bob_d;
  logic              bob_down_q, bob_down_d;
  logic [3:0]        step_q, step_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              active_q, active_d;
  logic              esc_q, esc_d;

  logic [9:0] lfsr;
  logic       unused_lfsr_msb;
  coord_t     spawn_raw;
  coord_t     spawn_y;

  lfsr10 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .lfsr_o (lfsr)
  );

  // Only the low nine bits pick the depth; the MSB just keeps the sequence long.
  assign unused_lfsr_msb = lfsr[9];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= SPAWN_X;
      y_q        <= CENTER_Y;
      base_q     <= CENTER_Y;
      bob_q      <= '0;
      bob_down_q <= 1'b1;
      step_q     <= '0;
      wait_q     <= '0;
      active_q   <= 1'b0;
      esc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      base_q     <= base_d;
      bob_q      <= bob_d;
      bob_down_q <= bob_down_d;
      step_q     <= step_d;
      wait_q     <= wait_d;
      active_q   <= active_d;
      esc_q      <= esc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    base_d     = base_q;
    bob_d      = bob_q;
    bob_down_d = bob_down_q;
    step_d     = step_q;
    wait_d     = wait_q;
    active_d   = active_q;
    esc_d      = 1'b0;

    // Spawn depth: V_TOP plus nine random bits covers 40..551; folding the overshoot
    // back by 256 keeps the spread inside the band before the final clamp.
    spawn_raw = V_TOP_C + coord_t'({3'b000, lfsr[8:0]});
    if (spawn_raw > V_BOT_C) begin
      spawn_raw = spawn_raw - WRAP;
    end
    spawn_y = clamp_coord(spawn_raw, BAND_LO, BAND_HI);

    if (!enable) begin
      state_d  = IDLE;
      active_d = 1'b0;
      x_d      = SPAWN_X;
    end else begin
      unique case (state_q)
        IDLE: begin
          x_d      = SPAWN_X;
          active_d = 1'b0;
          state_d  = SPAWN;
        end

        SPAWN: begin
          base_d     = spawn_y;
          x_d        = SPAWN_X;
          bob_d      = '0;
          bob_down_d = 1'b1;
          step_d     = '0;
          active_d   = 1'b1;
          state_d    = SWIM;
        end

        SWIM: begin
          if (hit) begin
            // A hit wins over a coincident frame_tick: no move, no escape pulse.
            active_d = 1'b0;
            wait_d   = '0;
            state_d  = WAIT;
          end else if (frame_tick) begin
            bob_d = bob_down_q ? (bob_q + ONE) : (bob_q - ONE);
            if (bob_d == AMP_P) begin
              bob_down_d = 1'b0;
            end else if (bob_d == AMP_N) begin
              bob_down_d = 1'b1;
            end

            if ((step_q + STEP_ONE) == STEP_DIV_C) begin
              step_d = '0;
              x_d    = x_q - SPEED_C;
            end else begin
              step_d = step_q + STEP_ONE;
            end

            if (x_d <= ESC_X) begin
              esc_d    = 1'b1;
              active_d = 1'b0;
              wait_d   = '0;
              state_d  = WAIT;
            end
          end
        end

        WAIT: begin
          if (frame_tick) begin
            if ((wait_q + WAIT_ONE) == WAIT_END) begin
              wait_d  = '0;
              state_d = SPAWN;
            end else begin
              wait_d = wait_q + WAIT_ONE;
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    y_d = base_d + bob_d;
  end

  assign sharkX  = x_q;
  assign sharkY  = y_q;
  assign active  = active_q;
  assign escaped = esc_q;

endmodule

// File: tb/tb_shark_mover.sv
// tb_shark_mover: randomized and directed stimulus for shark_mover, checked every cycle
// against a behavioural model (position from tick count, bob as a triangle wave).
// Expected outputs are queued by the driver and popped by an independent monitor.

module tb_shark_mover;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               frame_tick = 1'b0;
  logic               enable = 1'b0;
  logic               hit = 1'b0;
  logic signed [11:0] sharkX;
  logic signed [11:0] sharkY;
  logic               active;
  logic               escaped;
  bit                 clk_run = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  shark_mover dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .enable     (enable),
    .hit        (hit),
    .sharkX     (sharkX),
    .sharkY     (sharkY),
    .active     (active),
    .escaped    (escaped)
  );

  initial begin
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_SPAWN = 1, M_SWIM = 2, M_WAIT = 3;

  int       m_mode, m_x, m_y, m_base, m_ticks, m_waits, m_act, m_esc;
  bit [9:0] m_lfsr;

  typedef struct {
    int x;
    int y;
    int act;
    int esc;
  } exp_t;
  exp_t exp_q[$];

  // Bob offset after n frame ticks: triangle 0 -> +8 -> -8 -> 0, period 32.
  function automatic int tri_bob(input int n);
    int p;
    p = n % 32;
    if (p <= 8) return p;
    if (p <= 24) return 16 - p;
    return p - 32;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_x = 696; m_y = 240; m_base = 240;
    m_ticks = 0; m_waits = 0; m_act = 0; m_esc = 0;
    m_lfsr = 10'h2A5;
  endtask

  task automatic model_advance(input bit fi, input bit h, input bit en);
    bit [9:0] l;
    int y;
    l = m_lfsr;
    m_lfsr = {l[8:0], l[9] ^ l[6]};
    m_esc = 0;
    if (!en) begin
      m_mode = M_IDLE; m_x = 696; m_act = 0;
    end else begin
      case (m_mode)
        M_IDLE: m_mode = M_SPAWN;
        M_SPAWN: begin
          y = 40 + int'(l[8:0]);
          if (y > 440) y = y - 256;
          if (y < 48) y = 48;
          if (y > 432) y = 432;
          m_base = y; m_y = y; m_x = 696; m_ticks = 0; m_act = 1;
          m_mode = M_SWIM;
        end
        M_SWIM: begin
          if (h) begin
            m_act = 0; m_waits = 0; m_mode = M_WAIT;
          end else if (fi) begin
            m_ticks++;
            m_x = 696 - 2 * m_ticks;
            m_y = m_base + tri_bob(m_ticks);
            if (m_x + 2 < 0) begin
              m_esc = 1; m_act = 0; m_waits = 0; m_mode = M_WAIT;
            end
          end
        end
        default: begin
          if (fi) begin
            m_waits++;
            if (m_waits == 30) m_mode = M_SPAWN;
          end
        end
      endcase
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("mon_sharkX", int'(sharkX), e.x);
        chk("mon_sharkY", int'(sharkY), e.y);
        chk("mon_active", int'(active), e.act);
        chk("mon_escaped", int'(escaped), e.esc);
      end
    end
  end

  // Drives one cycle of inputs, queues the model's post-edge outputs, returns at the next negedge.
  task automatic step(input bit fi, input bit h, input bit en);
    exp_t e;
    frame_tick = fi;
    hit = h;
    enable = en;
    model_advance(fi, h, en);
    e.x = m_x; e.y = m_y; e.act = m_act; e.esc = m_esc;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    model_reset();
    #1 rst = 1'b1;
    #2;
    chk("rst_sharkX", int'(sharkX), 696);
    chk("rst_sharkY", int'(sharkY), 240);
    chk("rst_active", int'(active), 0);
    chk("rst_escaped", int'(escaped), 0);

    clk_run = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Enable: IDLE -> SPAWN -> SWIM.
    step(0, 0, 1);
    step(0, 0, 1);
    chk("spawn_active", int'(active), 1);
    chk("spawn_sharkX", int'(sharkX), 696);
    chk("spawn_sharkY", int'(sharkY), m_y);
    chk("spawn_y_in_band", int'((sharkY >= 48) && (sharkY <= 432)), 1);

    // Ten frame ticks with idle cycles between them.
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 1);
      step(0, 0, 1);
    end
    chk("swim10_sharkX", int'(sharkX), 676);
    chk("swim10_sharkY", int'(sharkY), m_base + 6);

    // Swim to the left edge.
    for (int t = 11; t <= 349; t++) step(1, 0, 1);
    chk("tick349_sharkX", int'(sharkX), -2);
    chk("tick349_active", int'(active), 1);
    step(1, 0, 1);
    chk("tick350_sharkX", int'(sharkX), -4);
    chk("tick350_escaped", int'(escaped), 1);
    chk("tick350_active", int'(active), 0);
    step(0, 0, 1);
    chk("escape_pulse_width", int'(escaped), 0);
    for (int t = 1; t <= 30; t++) step(1, 0, 1);
    chk("wait30_active", int'(active), 0);
    step(0, 0, 1);
    chk("respawn_active", int'(active), 1);
    chk("respawn_sharkX", int'(sharkX), 696);

    // Hit coincident with frame_tick.
    for (int i = 0; i < 5; i++) step(1, 0, 1);
    step(1, 1, 1);
    chk("hit_sharkX", int'(sharkX), 686);
    chk("hit_active", int'(active), 0);
    chk("hit_escaped", int'(escaped), 0);
    // Hits inside WAIT must not disturb the respawn count.
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 1);
      step(0, 1, 1);
    end
    for (int i = 0; i < 19; i++) step(1, 0, 1);
    chk("wait_hit29_active", int'(active), 0);
    step(1, 0, 1);
    step(0, 0, 1);
    chk("wait_hit_respawn_active", int'(active), 1);

    // Enable drop mid-swim, then an asynchronous reset pulse between edges.
    for (int i = 0; i < 4; i++) step(1, 0, 1);
    step(1, 0, 0);
    chk("disable_active", int'(active), 0);
    chk("disable_sharkX", int'(sharkX), 696);
    step(0, 0, 1);
    step(0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("arst_sharkX", int'(sharkX), 696);
    chk("arst_sharkY", int'(sharkY), 240);
    chk("arst_active", int'(active), 0);
    chk("arst_escaped", int'(escaped), 0);
    #1 rst = 1'b0;

    // Randomized run.
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 299) != 0));
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
